// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module   : deserializer
// Brief    : Serial-to-parallel front end, MSB-first, with one-cycle push
//            strobe into a byte queue that can back-pressure via occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module deserializer #(
    parameter int WIDTH       = 8,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic [7:0]       len_in,
    output logic [WIDTH-1:0] data_out,
    output logic             enqueue_out,
    output logic             status_out,
    output logic [3:0]       bit_count_out
);

    localparam logic [3:0] c_LAST_BIT = 4'(WIDTH - 1);
    localparam logic [8:0] c_DEPTH    = 9'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_HOLD    = 2'd1,
        S_PUSH    = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    // Only WIDTH-1 history bits are kept: the final bit goes straight to data_out.
    logic [WIDTH-2:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] r_data,  w_data_nxt;
    logic             r_enq,   w_enq_nxt;
    logic             r_status, w_status_nxt;
    logic [3:0]       r_count, w_count_nxt;
    logic             w_space;

    assign w_space = ({1'b0, len_in} < c_DEPTH);

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            r_state  <= S_COLLECT;
            r_shift  <= '0;
            r_data   <= '0;
            r_enq    <= 1'b0;
            r_status <= 1'b0;
            r_count  <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_data   <= w_data_nxt;
            r_enq    <= w_enq_nxt;
            r_status <= w_status_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_data_nxt   = r_data;
        w_enq_nxt    = 1'b0;
        w_status_nxt = r_status;
        w_count_nxt  = r_count;
        case (r_state)
            S_COLLECT: begin
                if (write_in) begin
                    w_shift_nxt = {r_shift[WIDTH-3:0], data_in};
                    if (r_count == c_LAST_BIT) begin
                        w_data_nxt   = {r_shift, data_in};
                        w_count_nxt  = 4'd0;
                        w_status_nxt = 1'b1;
                        w_state_nxt  = S_HOLD;
                    end else begin
                        w_count_nxt = r_count + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (w_space) begin
                    w_enq_nxt   = 1'b1;
                    w_state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                w_status_nxt = 1'b0;
                w_state_nxt  = S_COLLECT;
            end
            default: begin
                w_status_nxt = 1'b0;
                w_state_nxt  = S_COLLECT;
            end
        endcase
    end

    assign data_out      = r_data;
    assign enqueue_out   = r_enq;
    assign status_out    = r_status;
    assign bit_count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserializer
// Brief    : Self-checking bench for deserializer (directed + randomized).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_deserializer;

    logic       clk_10KHz = 1'b0;
    logic       reset     = 1'b0;
    logic       data_in   = 1'b0;
    logic       write_in  = 1'b0;
    logic [7:0] len_in    = 8'd0;
    logic [7:0] data_out;
    logic       enqueue_out;
    logic       status_out;
    logic [3:0] bit_count_out;

    int errors = 0;
    int checks = 0;

    deserializer #(.WIDTH(8), .QUEUE_DEPTH(8)) dut (
        .clk_10KHz    (clk_10KHz),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .len_in       (len_in),
        .data_out     (data_out),
        .enqueue_out  (enqueue_out),
        .status_out   (status_out),
        .bit_count_out(bit_count_out)
    );

    always #5 clk_10KHz = ~clk_10KHz;

    // Drive inputs, take one clock edge, then settle before sampling.
    task automatic step(input logic wr, input logic d);
        write_in = wr;
        data_in  = d;
        @(posedge clk_10KHz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++; if (enqueue_out !== 1'b0) begin errors++; $display("FAIL reset_enq: got %b want 0", enqueue_out); end
        checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL reset_status: got %b want 0", status_out); end
        checks++; if (bit_count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bit_count_out); end
        @(negedge clk_10KHz);
        reset = 1'b1;
        @(posedge clk_10KHz); #1;
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hA5;
        len_in = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, w[i]);
            checks++; if (bit_count_out !== 4'((8 - i) % 8)) begin errors++; $display("FAIL basic_count: got %0d want %0d", bit_count_out, (8 - i) % 8); end
        end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", data_out); end
        checks++; if (status_out !== 1'b1) begin errors++; $display("FAIL basic_status_hold: got %b want 1", status_out); end
        checks++; if (enqueue_out !== 1'b0) begin errors++; $display("FAIL basic_enq_early: got %b want 0", enqueue_out); end
        step(1'b0, 1'b0);
        checks++; if (enqueue_out !== 1'b1) begin errors++; $display("FAIL basic_enq_pulse: got %b want 1", enqueue_out); end
        step(1'b0, 1'b0);
        checks++; if (enqueue_out !== 1'b0) begin errors++; $display("FAIL basic_enq_end: got %b want 0", enqueue_out); end
        checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL basic_status_done: got %b want 0", status_out); end
    endtask

    task automatic test_queue_full();
        logic [7:0] w;
        w = 8'h3C;
        len_in = 8'd8;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
        for (int c = 0; c < 20; c++) begin
            step(logic'(c % 2), 1'b1);
            checks++;
            if (enqueue_out !== 1'b0 || status_out !== 1'b1 || data_out !== 8'h3C || bit_count_out !== 4'd0) begin
                errors++;
                $display("FAIL full_hold c=%0d: got enq=%b st=%b data=%h cnt=%0d want enq=0 st=1 data=3c cnt=0",
                         c, enqueue_out, status_out, data_out, bit_count_out);
            end
        end
        len_in = 8'd7;
        step(1'b0, 1'b0);
        checks++; if (enqueue_out !== 1'b1 || data_out !== 8'h3C) begin errors++; $display("FAIL full_release: got enq=%b data=%h want enq=1 data=3c", enqueue_out, data_out); end
        step(1'b0, 1'b0);
        checks++; if (enqueue_out !== 1'b0 || status_out !== 1'b0) begin errors++; $display("FAIL full_after: got enq=%b st=%b want 0 0", enqueue_out, status_out); end
        len_in = 8'd0;
    endtask

    task automatic test_gapped();
        int pulses;
        pulses = 0;
        len_in = 8'd0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b1, 1'b1);
            checks++; if (bit_count_out !== 4'((i + 1) % 8)) begin errors++; $display("FAIL gap_count: got %0d want %0d", bit_count_out, (i + 1) % 8); end
        end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL gap_data: got %h want ff", data_out); end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b0);
            if (enqueue_out === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'h81;
        len_in = 8'd0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        write_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00 || enqueue_out !== 1'b0 || status_out !== 1'b0 || bit_count_out !== 4'd0) begin
            errors++;
            $display("FAIL midword_reset: got data=%h enq=%b st=%b cnt=%0d want all 0", data_out, enqueue_out, status_out, bit_count_out);
        end
        @(posedge clk_10KHz); #1;
        reset = 1'b1;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
        checks++; if (data_out !== 8'h81 || status_out !== 1'b1) begin errors++; $display("FAIL midword_data: got %h st=%b want 81 st=1", data_out, status_out); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic       stream[$];
        logic [7:0] pushed[$];
        int         push_cyc[$];
        logic [7:0] a, b;
        a = 8'h12; b = 8'h34;
        len_in = 8'd0;
        for (int i = 7; i >= 0; i--) stream.push_back(a[i]);
        stream.push_back(1'b1); stream.push_back(1'b1);   // land during HOLD/PUSH, must be dropped
        for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
        stream.push_back(1'b1); stream.push_back(1'b1);
        for (int c = 0; c < stream.size() + 4; c++) begin
            if (c < stream.size()) step(1'b1, stream[c]); else step(1'b0, 1'b0);
            if (enqueue_out === 1'b1) begin pushed.push_back(data_out); push_cyc.push_back(c); end
        end
        checks++;
        if (pushed.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d pushes want 2", pushed.size());
        end else begin
            checks++; if (pushed[0] !== a) begin errors++; $display("FAIL b2b_first: got %h want %h", pushed[0], a); end
            checks++; if (pushed[1] !== b) begin errors++; $display("FAIL b2b_second: got %h want %h", pushed[1], b); end
            checks++; if (push_cyc[1] - push_cyc[0] < 10) begin errors++; $display("FAIL b2b_spacing: got %0d want >=10", push_cyc[1] - push_cyc[0]); end
        end
    endtask

    task automatic test_reset_hold();
        logic [7:0] w;
        int         pulses;
        w = 8'h5A; pulses = 0;
        len_in = 8'd8;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
        step(1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        checks++; if (status_out !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL hold_reset: got st=%b data=%h want 0 00", status_out, data_out); end
        @(posedge clk_10KHz); #1;
        reset  = 1'b1;
        len_in = 8'd0;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b0);
            if (enqueue_out === 1'b1 || status_out !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL hold_discard: got %0d bad cycles want 0", pulses); end
    endtask

    // Reference: a word is the 8 accepted bits packed MSB-first; it is pushed on
    // the first cycle after completion whose sampled occupancy is below 8.
    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            logic [7:0] w;
            int         got, full_cycles, accepted;
            w = 8'($urandom);
            accepted = 0;
            for (int i = 7; i >= 0; i--) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    len_in = 8'($urandom);
                    step(1'b0, 1'($urandom));
                end
                len_in = 8'($urandom);
                step(1'b1, w[i]);
                accepted++;
                checks++; if (bit_count_out !== 4'(accepted % 8)) begin errors++; $display("FAIL rnd_count n=%0d: got %0d want %0d", n, bit_count_out, accepted % 8); end
            end
            checks++; if (data_out !== w || status_out !== 1'b1) begin errors++; $display("FAIL rnd_data n=%0d: got %h st=%b want %h st=1", n, data_out, status_out, w); end
            full_cycles = $urandom_range(0, 4);
            got = 0;
            for (int c = 0; c < full_cycles; c++) begin
                len_in = 8'($urandom_range(8, 255));
                step(1'($urandom), 1'($urandom));
                if (enqueue_out !== 1'b0 || data_out !== w) got++;
            end
            checks++; if (got != 0) begin errors++; $display("FAIL rnd_full n=%0d: got %0d bad cycles want 0", n, got); end
            len_in = 8'($urandom_range(0, 7));
            step(1'($urandom), 1'($urandom));
            checks++; if (enqueue_out !== 1'b1 || data_out !== w) begin errors++; $display("FAIL rnd_push n=%0d: got enq=%b data=%h want 1 %h", n, enqueue_out, data_out, w); end
            step(1'($urandom), 1'($urandom));
            checks++; if (enqueue_out !== 1'b0 || status_out !== 1'b0 || bit_count_out !== 4'd0) begin errors++; $display("FAIL rnd_done n=%0d: got enq=%b st=%b cnt=%0d want 0 0 0", n, enqueue_out, status_out, bit_count_out); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_queue_full();
        test_gapped();
        test_reset_mid_word();
        test_back_to_back();
        test_reset_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
